// File: rtl/msu_pkg.sv
// rtl/msu_pkg.sv - shared constants and types for the modular squaring datapath
package msu_pkg;

  localparam int MOD_LEN             = 1024;
  localparam int WORD_LEN            = 16;
  localparam int BIT_LEN             = 17;
  localparam int REDUNDANT_ELEMENTS  = 1;
  localparam int NUM_ELEMENTS        = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS;
  localparam int SLOT_BITS           = 2 * WORD_LEN;
  localparam int SQ_OUT_BITS         = NUM_ELEMENTS * SLOT_BITS;
  localparam int RES_BITS            = NUM_ELEMENTS * WORD_LEN;
  localparam int DEF_ELEMS_PER_CYCLE = 5;

  typedef logic [BIT_LEN-1:0]  coeff_t;
  typedef logic [WORD_LEN-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } norm_state_t;

endpackage

// File: rtl/carry_slice.sv
// rtl/carry_slice.sv - combinational carry fold of one slice of redundant coefficients
module carry_slice
  import msu_pkg::*;
#(
  parameter int ELEMS = DEF_ELEMS_PER_CYCLE
) (
  input  coeff_t     coeff [ELEMS],
  input  logic [1:0] carry_in,
  output word_t      word  [ELEMS],
  output logic [1:0] carry_out
);

  // A 17-bit coefficient plus a carry of at most 2 never exceeds 0x20001,
  // so the carry into the next word always fits in two bits.
  always_comb begin : fold
    logic [1:0]       c;
    logic [BIT_LEN:0] s;
    c    = carry_in;
    s    = '0;
    word = '{default: '0};
    for (int i = 0; i < ELEMS; i++) begin
      s       = {1'b0, coeff[i]} + (BIT_LEN + 1)'(c);
      word[i] = s[WORD_LEN-1:0];
      c       = s[WORD_LEN+1:WORD_LEN];
    end
    carry_out = c;
  end

endmodule

// File: rtl/sq_out_normalizer.sv
// rtl/sq_out_normalizer.sv - multi-cycle carry propagation of squarer output into a plain integer
module sq_out_normalizer
  import msu_pkg::*;
#(
  parameter int ELEMS_PER_CYCLE = DEF_ELEMS_PER_CYCLE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SQ_OUT_BITS-1:0] sq_out,
  input  logic                   valid,
  output logic [RES_BITS-1:0]    result,
  output logic [1:0]             result_carry,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overrun
);

  localparam int STEPS      = NUM_ELEMENTS / ELEMS_PER_CYCLE;
  localparam int STEP_W     = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SLICE_BITS = ELEMS_PER_CYCLE * WORD_LEN;

  if (NUM_ELEMENTS % ELEMS_PER_CYCLE != 0) begin : g_bad_fold
    $error("ELEMS_PER_CYCLE must divide NUM_ELEMENTS");
  end

  norm_state_t           state_q, state_d;
  coeff_t                coeff_q [NUM_ELEMENTS];
  logic [1:0]            carry_q;
  logic [STEP_W-1:0]     step_q;
  coeff_t                slice_coeff [ELEMS_PER_CYCLE];
  word_t                 slice_word  [ELEMS_PER_CYCLE];
  logic [1:0]            slice_carry;
  logic [SLICE_BITS-1:0] slice_bits;
  logic                  load;
  logic                  drop;
  logic                  last_step;
  logic                  unused_slot_bits;

  // Only the low BIT_LEN bits of each 32-bit slot carry value.
  assign unused_slot_bits = ^sq_out;
  assign last_step        = (step_q == STEP_W'(STEPS - 1));

  always_comb begin
    slice_coeff = '{default: '0};
    slice_bits  = '0;
    for (int i = 0; i < ELEMS_PER_CYCLE; i++) begin
      slice_coeff[i]                       = coeff_q[i];
      slice_bits[i*WORD_LEN +: WORD_LEN]   = slice_word[i];
    end
  end

  carry_slice #(
    .ELEMS(ELEMS_PER_CYCLE)
  ) u_carry_slice (
    .coeff    (slice_coeff),
    .carry_in (carry_q),
    .word     (slice_word),
    .carry_out(slice_carry)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        drop = valid;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (valid) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          drop = valid;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == DONE);
      overrun   <= drop;
    end
  end

  // Words leave the slice lowest-first and enter result at the top, so after
  // STEPS shifts word 0 has settled at the bottom.
  always_ff @(posedge clk) begin
    if (reset) begin
      coeff_q      <= '{default: '0};
      carry_q      <= '0;
      step_q       <= '0;
      result       <= '0;
      result_carry <= '0;
    end else if (load) begin
      for (int j = 0; j < NUM_ELEMENTS; j++) begin
        coeff_q[j] <= sq_out[j*SLOT_BITS +: BIT_LEN];
      end
      carry_q <= '0;
      step_q  <= '0;
    end else if (state_q == RUN) begin
      for (int j = 0; j < NUM_ELEMENTS - ELEMS_PER_CYCLE; j++) begin
        coeff_q[j] <= coeff_q[j+ELEMS_PER_CYCLE];
      end
      for (int j = NUM_ELEMENTS - ELEMS_PER_CYCLE; j < NUM_ELEMENTS; j++) begin
        coeff_q[j] <= '0;
      end
      result  <= {slice_bits, result[RES_BITS-1:SLICE_BITS]};
      carry_q <= slice_carry;
      step_q  <= step_q + 1'b1;
      if (last_step) result_carry <= slice_carry;
    end
  end

endmodule

// File: tb/tb_sq_out_normalizer.sv
// tb/tb_sq_out_normalizer.sv - scoreboard bench for sq_out_normalizer
module tb_sq_out_normalizer;
  import msu_pkg::*;

  typedef logic [RES_BITS+1:0]    exp_t;
  typedef logic [SQ_OUT_BITS-1:0] bus_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                valid;
  logic                out_ready;
  logic                out_valid;
  logic                overrun;
  bus_t                sq_out;
  logic [RES_BITS-1:0] result;
  logic [1:0]          result_carry;

  exp_t sb[$];
  exp_t mon_exp;
  exp_t e;
  bus_t d;
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   fw;
  bit   ov_expect  = 1'b0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  sq_out_normalizer dut (
    .clk         (clk),
    .reset       (reset),
    .sq_out      (sq_out),
    .valid       (valid),
    .result      (result),
    .result_carry(result_carry),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun)
  );

  function automatic exp_t ref_sum(input bus_t s);
    exp_t acc;
    exp_t term;
    acc = '0;
    for (int j = 0; j < NUM_ELEMENTS; j++) begin
      term                = '0;
      term[BIT_LEN-1:0]   = s[j*SLOT_BITS +: BIT_LEN];
      acc                 = acc + (term << (WORD_LEN * j));
    end
    return acc;
  endfunction

  function automatic bus_t fill(input logic [31:0] slot);
    bus_t b;
    for (int j = 0; j < NUM_ELEMENTS; j++) b[j*SLOT_BITS +: SLOT_BITS] = slot;
    return b;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got[63:0], want[63:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bus_t data, input exp_t want);
    sb.push_back(want);
    sq_out = data;
    valid  = 1'b1;
    tick();
    valid  = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      tick();
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d want=0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // Every cycle out_valid is up the held result must match the head expectation.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid got=1 want=0");
      end else begin
        mon_exp = sb[0];
        if ({result_carry, result} !== mon_exp) begin
          errors++;
          fw = 0;
          for (int j = NUM_ELEMENTS - 1; j >= 0; j--)
            if (result[j*WORD_LEN +: WORD_LEN] !== mon_exp[j*WORD_LEN +: WORD_LEN]) fw = j;
          $display("FAIL result word%0d got=%h want=%h carry got=%0d want=%0d", fw,
                   result[fw*WORD_LEN +: WORD_LEN], mon_exp[fw*WORD_LEN +: WORD_LEN],
                   result_carry, mon_exp[RES_BITS+1:RES_BITS]);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
    if (!reset && (overrun || ov_expect)) begin
      checks++;
      if (overrun !== ov_expect) begin
        errors++;
        $display("FAIL overrun got=%0b want=%0b", overrun, ov_expect);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    valid     = 1'b0;
    out_ready = 1'b0;
    sq_out    = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_out_valid", exp_t'(out_valid), '0);
    check("reset_overrun", exp_t'(overrun), '0);
    check("reset_result", exp_t'(result), '0);
    check("reset_carry", exp_t'(result_carry), '0);

    // Slot garbage above bit 16, coefficient 0xFFFF: all-ones words, no carry.
    out_ready = 1'b1;
    e = '0;
    e[RES_BITS-1:0] = '1;
    issue(fill(32'hFFFE_FFFF), e);
    wait_out(n);
    check("latency_first", exp_t'(n), exp_t'(13));
    drain();

    // All 0x1FFFF: word0 FFFF, word1 0000, words 2..64 0001, carry 2.
    e = '0;
    e[15:0] = 16'hFFFF;
    for (int j = 2; j < NUM_ELEMENTS; j++) e[j*WORD_LEN +: WORD_LEN] = 16'h0001;
    e[RES_BITS+1:RES_BITS] = 2'd2;
    issue(fill(32'h0001_FFFF), e);
    drain();

    issue('0, '0);
    drain();

    // Only bit 16 of coefficient 0 (upper slot bits junk) lands in word 1.
    d = '0;
    d[31:0] = 32'hABCD_0000;
    e = '0;
    e[WORD_LEN] = 1'b1;
    issue(d, e);
    drain();

    // Top coefficient overflows into result_carry.
    d = '0;
    d[64*SLOT_BITS +: SLOT_BITS] = 32'h0001_FFFF;
    e = '0;
    e[64*WORD_LEN +: WORD_LEN] = 16'hFFFF;
    e[RES_BITS+1:RES_BITS] = 2'd1;
    issue(d, e);
    drain();

    // Overrun while in RUN: only the first conversion is produced.
    e = '0;
    for (int j = 0; j < NUM_ELEMENTS; j++) e[j*WORD_LEN +: WORD_LEN] = 16'h1234;
    issue(fill(32'h0000_1234), e);
    repeat (4) tick();
    sq_out = fill(32'h0000_5555);
    valid  = 1'b1;
    tick();
    valid     = 1'b0;
    ov_expect = 1'b1;
    tick();
    ov_expect = 1'b0;
    drain();
    repeat (20) tick();

    // Overrun while DONE is stalled.
    out_ready = 1'b0;
    issue(fill(32'h0000_1234), e);
    wait_out(n);
    sq_out = fill(32'h0000_5555);
    valid  = 1'b1;
    tick();
    valid     = 1'b0;
    ov_expect = 1'b1;
    tick();
    ov_expect = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    drain();
    repeat (20) tick();

    // Capture in the same cycle as the DONE handshake.
    out_ready = 1'b0;
    issue(fill(32'h0000_1234), e);
    wait_out(n);
    e = '0;
    for (int j = 0; j < NUM_ELEMENTS; j++) e[j*WORD_LEN +: WORD_LEN] = 16'h0042;
    sb.push_back(e);
    sq_out    = fill(32'h0000_0042);
    valid     = 1'b1;
    out_ready = 1'b1;
    tick();
    valid     = 1'b0;
    out_ready = 1'b0;
    wait_out(n);
    check("latency_back_to_back", exp_t'(n), exp_t'(13));
    out_ready = 1'b1;
    drain();

    // Reset at step 7 aborts the conversion.
    e = '0;
    for (int j = 0; j < NUM_ELEMENTS; j++) e[j*WORD_LEN +: WORD_LEN] = 16'h1234;
    issue(fill(32'h0000_1234), e);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    check("midrun_reset_out_valid", exp_t'(out_valid), '0);
    check("midrun_reset_result", exp_t'(result), '0);
    check("midrun_reset_carry", exp_t'(result_carry), '0);
    check("midrun_reset_overrun", exp_t'(overrun), '0);
    reset = 1'b0;
    sb.delete();
    d = fill(32'h0000_0007);
    issue(d, ref_sum(d));
    drain();

    rand_ready = 1'b1;
    for (int it = 0; it < 1000; it++) begin
      for (int j = 0; j < NUM_ELEMENTS; j++) d[j*SLOT_BITS +: SLOT_BITS] = $urandom();
      issue(d, ref_sum(d));
      drain();
    end
    rand_ready = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
